// File: rtl/axis_arb_mux_n.sv
// axis_arb_mux_n: N-to-1 AXI-Stream mux with packet-locked external-select or round-robin arbitration.
// Define AXIS_ARB_MUX_SKID_EN for a registered output stage with a one-entry skid buffer.
module axis_arb_mux_n #(
   parameter int NUM_CH   = 4,
   parameter int WIDTH    = 16,
   parameter int ARB_MODE = 0,
   localparam int SEL_W   = $clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_CH*WIDTH-1:0] s_data,
   input  logic [NUM_CH-1:0]       s_valid,
   input  logic [NUM_CH-1:0]       s_last,
   output logic [NUM_CH-1:0]       s_ready,
   output logic [WIDTH-1:0]        m_data,
   output logic                    m_valid,
   output logic                    m_last,
   output logic [SEL_W-1:0]        m_chan,
   input  logic                    m_ready
);

   localparam bit RR_MODE = (ARB_MODE != 0);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t           state_r, state_nxt_s;
   logic [SEL_W-1:0] grant_r, grant_nxt_s;
   logic [SEL_W-1:0] rr_ptr_r, rr_ptr_nxt_s;
   logic [SEL_W-1:0] cand_s, src_s;
   logic             cand_ok_s, src_ok_s;
   logic             src_valid_s, src_last_s;
   logic [WIDTH-1:0] src_data_s;
   logic             accept_s, xfer_s;
   int               dist_s, best_dist_s;

   // IDLE candidate: external select, or nearest requester after rr_ptr with wrap-around.
   always_comb begin
      cand_s      = '0;
      cand_ok_s   = 1'b0;
      dist_s      = 0;
      best_dist_s = NUM_CH;
      if (!RR_MODE) begin
         cand_s    = sel;
         cand_ok_s = (int'(sel) < NUM_CH);
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            dist_s = (i + NUM_CH - 1 - int'(rr_ptr_r)) % NUM_CH;
            if (s_valid[i] && (dist_s < best_dist_s)) begin
               best_dist_s = dist_s;
               cand_s      = SEL_W'(i);
               cand_ok_s   = 1'b1;
            end else begin
               best_dist_s = best_dist_s;
            end
         end
      end
   end

   // Source channel: the held grant mid-packet, otherwise the IDLE candidate.
   always_comb begin
      src_data_s  = '0;
      src_valid_s = 1'b0;
      src_last_s  = 1'b0;
      if (state_r == ST_LOCKED) begin
         src_s    = grant_r;
         src_ok_s = 1'b1;
      end else begin
         src_s    = cand_s;
         src_ok_s = cand_ok_s;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (src_s == SEL_W'(i)) begin
            src_data_s  = s_data[i*WIDTH +: WIDTH];
            src_valid_s = s_valid[i];
            src_last_s  = s_last[i];
         end else begin
            src_valid_s = src_valid_s;
         end
      end
      src_valid_s = src_valid_s & src_ok_s & rst_n;
   end

   // Upstream ready: only the source channel may see ready, never while in reset.
   always_comb begin
      s_ready = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (src_ok_s && rst_n && (src_s == SEL_W'(i))) begin
            s_ready[i] = accept_s & ((state_r == ST_LOCKED) | s_valid[i]);
         end else begin
            s_ready[i] = 1'b0;
         end
      end
   end

   assign xfer_s = src_valid_s & accept_s;

   // Next-state logic: lock on a non-last first beat, release and advance rr_ptr on the last beat.
   always_comb begin
      state_nxt_s  = state_r;
      grant_nxt_s  = grant_r;
      rr_ptr_nxt_s = rr_ptr_r;
      case (state_r)
         ST_IDLE: begin
            if (xfer_s) begin
               if (src_last_s) begin
                  if (RR_MODE) begin
                     rr_ptr_nxt_s = cand_s;
                  end else begin
                     rr_ptr_nxt_s = rr_ptr_r;
                  end
               end else begin
                  state_nxt_s = ST_LOCKED;
                  grant_nxt_s = cand_s;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            if (xfer_s && src_last_s) begin
               state_nxt_s = ST_IDLE;
               if (RR_MODE) begin
                  rr_ptr_nxt_s = grant_r;
               end else begin
                  rr_ptr_nxt_s = rr_ptr_r;
               end
            end else begin
               state_nxt_s = ST_LOCKED;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Arbitration state register; rr_ptr resets to the last channel so channel 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         grant_r  <= '0;
         rr_ptr_r <= SEL_W'(NUM_CH - 1);
      end else begin
         state_r  <= state_nxt_s;
         grant_r  <= grant_nxt_s;
         rr_ptr_r <= rr_ptr_nxt_s;
      end
   end

`ifdef AXIS_ARB_MUX_SKID_EN
   logic             out_valid_r, out_last_r, skid_valid_r, skid_last_r;
   logic [WIDTH-1:0] out_data_r, skid_data_r;
   logic [SEL_W-1:0] out_chan_r, skid_chan_r;

   assign accept_s = ~skid_valid_r;

   // Output register plus skid entry; the skid catches the beat already in flight when m_ready drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r  <= 1'b0;
         out_last_r   <= 1'b0;
         out_data_r   <= '0;
         out_chan_r   <= '0;
         skid_valid_r <= 1'b0;
         skid_last_r  <= 1'b0;
         skid_data_r  <= '0;
         skid_chan_r  <= '0;
      end else if (!out_valid_r || m_ready) begin
         if (skid_valid_r) begin
            out_valid_r  <= 1'b1;
            out_last_r   <= skid_last_r;
            out_data_r   <= skid_data_r;
            out_chan_r   <= skid_chan_r;
            skid_valid_r <= 1'b0;
         end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_last_r  <= src_last_s;
            out_data_r  <= src_data_s;
            out_chan_r  <= src_s;
         end else begin
            out_valid_r <= 1'b0;
         end
      end else if (xfer_s) begin
         skid_valid_r <= 1'b1;
         skid_last_r  <= src_last_s;
         skid_data_r  <= src_data_s;
         skid_chan_r  <= src_s;
      end else begin
         skid_valid_r <= skid_valid_r;
      end
   end

   assign m_valid = out_valid_r;
   assign m_last  = out_last_r;
   assign m_data  = out_data_r;
   assign m_chan  = out_chan_r;
`else
   assign accept_s = m_ready;

   // Pass-through output; forced to reset values while rst_n is low.
   always_comb begin
      if (rst_n) begin
         m_valid = src_valid_s;
         m_last  = src_last_s;
         m_data  = src_data_s;
         m_chan  = src_s;
      end else begin
         m_valid = 1'b0;
         m_last  = 1'b0;
         m_data  = '0;
         m_chan  = '0;
      end
   end
`endif

endmodule

// File: tb/tb_axis_arb_mux_n.sv
// Testbench for axis_arb_mux_n: randomized traffic against a packet-level arbitration/scoreboard model.
// Works with or without AXIS_ARB_MUX_SKID_EN defined.
module tb_axis_arb_mux_n;

   localparam int NUM_CH = 4;
   localparam int WIDTH  = 16;
   localparam int SEL_W  = 2;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic [SEL_W-1:0]        sel = '0;
   logic [NUM_CH*WIDTH-1:0] s_data = '0;
   logic [NUM_CH-1:0]       s_valid = '0;
   logic [NUM_CH-1:0]       s_last = '0;
   logic                    m_ready = 1'b1;

   logic [NUM_CH-1:0] rr_s_ready, sl_s_ready, a_ready;
   logic [WIDTH-1:0]  rr_m_data, sl_m_data, a_mdata;
   logic              rr_m_valid, sl_m_valid, a_mvalid;
   logic              rr_m_last, sl_m_last, a_mlast;
   logic [SEL_W-1:0]  rr_m_chan, sl_m_chan, a_mchan;

   axis_arb_mux_n #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .ARB_MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .sel(sel), .s_data(s_data), .s_valid(s_valid),
      .s_last(s_last), .s_ready(rr_s_ready), .m_data(rr_m_data), .m_valid(rr_m_valid),
      .m_last(rr_m_last), .m_chan(rr_m_chan), .m_ready(m_ready));

   axis_arb_mux_n #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .ARB_MODE(0)) u_sl (
      .clk(clk), .rst_n(rst_n), .sel(sel), .s_data(s_data), .s_valid(s_valid),
      .s_last(s_last), .s_ready(sl_s_ready), .m_data(sl_m_data), .m_valid(sl_m_valid),
      .m_last(sl_m_last), .m_chan(sl_m_chan), .m_ready(m_ready));

   always #5 clk = ~clk;

   bit use_sel = 1'b0;
   always_comb begin
      a_ready  = use_sel ? sl_s_ready : rr_s_ready;
      a_mdata  = use_sel ? sl_m_data  : rr_m_data;
      a_mvalid = use_sel ? sl_m_valid : rr_m_valid;
      a_mlast  = use_sel ? sl_m_last  : rr_m_last;
      a_mchan  = use_sel ? sl_m_chan  : rr_m_chan;
   end

   logic [WIDTH:0]         ch_q[NUM_CH][$];   // {last, data} still to be offered
   logic [SEL_W+WIDTH:0]   exp_q[$];          // {chan, last, data} accepted, not yet output
   logic [SEL_W:0]         out_log[$];        // {chan, last} of every output beat
   logic [NUM_CH-1:0]      hs_r = '0;
   int                     n_pass = 0, n_total = 0;
   bit                     m_locked;
   int                     m_grant, m_rr, first_ch, out_cnt;
   int                     in_cnt[NUM_CH];
   bit                     gap_en;
   int unsigned            rdy_pct;
   bit                     prev_stall;
   logic [WIDTH-1:0]       pd;
   logic                   pl;
   logic [SEL_W-1:0]       pc;

   task automatic add_pkt(input int ch, input int len);
      for (int b = 0; b < len; b++) ch_q[ch].push_back({(b == len - 1), WIDTH'($urandom)});
   endtask

   task automatic drive();
      for (int i = 0; i < NUM_CH; i++) begin
         if (hs_r[i] && ch_q[i].size() > 0) void'(ch_q[i].pop_front());
         if (!s_valid[i] || hs_r[i]) begin
            s_valid[i] = (ch_q[i].size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
            if (ch_q[i].size() > 0) begin
               s_last[i] = ch_q[i][0][WIDTH];
               s_data[i*WIDTH +: WIDTH] = ch_q[i][0][WIDTH-1:0];
            end
         end
      end
      hs_r = '0;
      m_ready = ($urandom_range(0, 99) < rdy_pct);
   endtask

   // Per-cycle observation: arbitration rule, scoreboard, output stability.
   task automatic observe();
      int exp_ch;
      logic [SEL_W+WIDTH:0] e;
      n_total++;
      if ($countones(a_ready) > 1) $display("FAIL onehot: s_ready=%b", a_ready);
      else n_pass++;
      if (m_locked) exp_ch = m_grant;
      else if (use_sel) exp_ch = int'(sel);
      else begin
         exp_ch = -1;
         for (int k = 1; k <= NUM_CH; k++)
            if (exp_ch < 0 && s_valid[(m_rr + k) % NUM_CH]) exp_ch = (m_rr + k) % NUM_CH;
      end
      if (a_ready != '0) begin
         n_total++;
         if (exp_ch < 0 || a_ready !== (4'b0001 << exp_ch))
            $display("FAIL grant: s_ready=%b expected channel %0d", a_ready, exp_ch);
         else n_pass++;
      end
      hs_r = a_ready & s_valid;
      for (int i = 0; i < NUM_CH; i++) begin
         if (hs_r[i]) begin
            exp_q.push_back({SEL_W'(i), s_last[i], s_data[i*WIDTH +: WIDTH]});
            in_cnt[i]++;
            if (first_ch < 0) first_ch = i;
            if (!m_locked) begin
               if (s_last[i]) begin
                  if (!use_sel) m_rr = i;
               end else begin
                  m_locked = 1'b1;
                  m_grant = i;
               end
            end else if (s_last[i]) begin
               m_locked = 1'b0;
               if (!use_sel) m_rr = m_grant;
            end
         end
      end
      if (prev_stall) begin
         n_total++;
         if ({a_mvalid, a_mdata, a_mlast, a_mchan} !== {1'b1, pd, pl, pc})
            $display("FAIL stable: got v=%b d=%h l=%b c=%0d want d=%h l=%b c=%0d",
                     a_mvalid, a_mdata, a_mlast, a_mchan, pd, pl, pc);
         else n_pass++;
      end
      if (a_mvalid && m_ready) begin
         n_total++;
         if (exp_q.size() == 0) $display("FAIL spurious: beat c=%0d d=%h with nothing accepted", a_mchan, a_mdata);
         else begin
            e = exp_q.pop_front();
            if ({a_mchan, a_mlast, a_mdata} !== e)
               $display("FAIL beat: got c=%0d l=%b d=%h want c=%0d l=%b d=%h",
                        a_mchan, a_mlast, a_mdata, e[SEL_W+WIDTH:WIDTH+1], e[WIDTH], e[WIDTH-1:0]);
            else n_pass++;
         end
         out_log.push_back({a_mchan, a_mlast});
         out_cnt++;
      end
`ifdef AXIS_ARB_MUX_SKID_EN
      prev_stall = a_mvalid && !m_ready;
`else
      prev_stall = a_mvalid && !m_ready && m_locked;
`endif
      pd = a_mdata; pl = a_mlast; pc = a_mchan;
   endtask

   task automatic step();
      @(negedge clk);
      if (rst_n) observe();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic clear_model();
      for (int i = 0; i < NUM_CH; i++) begin
         ch_q[i].delete();
         in_cnt[i] = 0;
      end
      exp_q.delete();
      out_log.delete();
      m_locked = 1'b0; m_grant = 0; m_rr = NUM_CH - 1;
      first_ch = -1; out_cnt = 0; prev_stall = 1'b0; hs_r = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_model();
      s_valid = '0; m_ready = 1'b1; rdy_pct = 100; gap_en = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic go();
      drive();
      #2;
      rst_n = 1'b1;
   endtask

   function automatic bit busy();
      bit b;
      b = (exp_q.size() > 0) || (s_valid != '0);
      for (int i = 0; i < NUM_CH; i++) b = b || (ch_q[i].size() > 0);
      return b;
   endfunction

   task automatic run_until_drained(input int bound, input bit sel_switch, input string name);
      int cyc;
      cyc = 0;
      while (busy() && cyc < bound) begin
         step();
         if (sel_switch && in_cnt[2] >= 1) sel = 2'd0;
         cyc++;
      end
      n_total++;
      if (busy()) $display("FAIL %s_timeout: traffic still pending after %0d cycles (want drained)", name, cyc);
      else n_pass++;
   endtask

   task automatic test_reset();
      use_sel = 1'b0;
      do_reset();
      for (int i = 0; i < NUM_CH; i++) add_pkt(i, 1);
      drive();
      @(negedge clk);
      n_total++;
      if (a_ready !== 4'b0000) $display("FAIL reset_s_ready: got %b want 0000", a_ready); else n_pass++;
      n_total++;
      if (a_mvalid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", a_mvalid); else n_pass++;
      n_total++;
      if ({a_mdata, a_mlast, a_mchan} !== '0)
         $display("FAIL reset_m_out: got d=%h l=%b c=%0d want 0", a_mdata, a_mlast, a_mchan);
      else n_pass++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_until_drained(50, 1'b0, "reset");
      n_total++;
      if (first_ch != 0) $display("FAIL reset_first: got channel %0d want 0", first_ch); else n_pass++;
   endtask

   task automatic test_rr_fairness();
      int xfers;
      use_sel = 1'b0;
      do_reset();
      for (int i = 0; i < NUM_CH; i++) for (int p = 0; p < 4; p++) add_pkt(i, 1);
      go();
      xfers = 0;
      for (int c = 0; c < 16; c++) begin
         step();
         if (hs_r != '0 || in_cnt[0] + in_cnt[1] + in_cnt[2] + in_cnt[3] > xfers) xfers++;
      end
      n_total++;
      if (xfers != 16) $display("FAIL rr_throughput: %0d transfers in 16 cycles want 16", xfers); else n_pass++;
      run_until_drained(50, 1'b0, "rr");
      n_total++;
      if (out_log.size() != 16) $display("FAIL rr_count: got %0d beats want 16", out_log.size()); else n_pass++;
      for (int k = 0; k < 16; k++) begin
         n_total++;
         if (out_log[k] !== {SEL_W'(k % NUM_CH), 1'b1})
            $display("FAIL rr_order[%0d]: got %b want chan %0d last 1", k, out_log[k], k % NUM_CH);
         else n_pass++;
      end
   endtask

   task automatic test_packet_lock();
      logic [SEL_W:0] want;
      use_sel = 1'b0;
      do_reset();
      add_pkt(1, 5);
      for (int p = 0; p < 3; p++) add_pkt(2, 1);
      go();
      run_until_drained(100, 1'b0, "lock");
      for (int k = 0; k < 6; k++) begin
         want = (k < 5) ? {2'd1, (k == 4)} : {2'd2, 1'b1};
         n_total++;
         if (out_log[k] !== want) $display("FAIL lock_seq[%0d]: got %b want %b", k, out_log[k], want);
         else n_pass++;
      end
   endtask

   task automatic test_select_lock();
      logic [SEL_W:0] want[4];
      want[0] = {2'd2, 1'b0}; want[1] = {2'd2, 1'b0}; want[2] = {2'd2, 1'b1}; want[3] = {2'd0, 1'b1};
      use_sel = 1'b1;
      do_reset();
      sel = 2'd2;
      add_pkt(2, 3);
      add_pkt(0, 1);
      go();
      run_until_drained(100, 1'b1, "sel");
      n_total++;
      if (out_log.size() != 4) $display("FAIL sel_count: got %0d beats want 4", out_log.size()); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         n_total++;
         if (out_log[k] !== want[k]) $display("FAIL sel_seq[%0d]: got %b want %b", k, out_log[k], want[k]);
         else n_pass++;
      end
      use_sel = 1'b0;
   endtask

   task automatic test_backpressure();
      int left;
      use_sel = 1'b0;
      do_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         left = 250;
         while (left > 0) begin
            int len;
            len = int'($urandom_range(1, 4));
            if (len > left) len = left;
            add_pkt(i, len);
            left -= len;
         end
      end
      gap_en = 1'b1;
      rdy_pct = 50;
      go();
      run_until_drained(20000, 1'b0, "bp");
      n_total++;
      if (out_cnt != 1000) $display("FAIL bp_count: got %0d beats want 1000", out_cnt); else n_pass++;
      for (int i = 0; i < NUM_CH; i++) begin
         n_total++;
         if (in_cnt[i] != 250) $display("FAIL bp_in[%0d]: got %0d beats want 250", i, in_cnt[i]);
         else n_pass++;
      end
   endtask

   task automatic test_midpacket_reset();
      int cyc;
      use_sel = 1'b0;
      do_reset();
      add_pkt(1, 4);
      add_pkt(3, 1);
      go();
      cyc = 0;
      while (in_cnt[1] < 2 && cyc < 20) begin
         step();
         cyc++;
      end
      n_total++;
      if (in_cnt[1] != 2) $display("FAIL mid_setup: got %0d beats from ch1 want 2", in_cnt[1]); else n_pass++;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (a_ready !== 4'b0000) $display("FAIL mid_s_ready: got %b want 0000", a_ready); else n_pass++;
      n_total++;
      if ({a_mvalid, a_mdata, a_mlast, a_mchan} !== '0)
         $display("FAIL mid_m_out: got v=%b d=%h l=%b c=%0d want 0", a_mvalid, a_mdata, a_mlast, a_mchan);
      else n_pass++;
      clear_model();
      s_valid = '0;
      add_pkt(2, 1);
      add_pkt(1, 1);
      add_pkt(0, 1);
      @(posedge clk);
      #1;
      go();
      run_until_drained(50, 1'b0, "mid");
      n_total++;
      if (first_ch != 0) $display("FAIL mid_first: got channel %0d want 0", first_ch); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_rr_fairness();
      test_packet_lock();
      test_select_lock();
      test_backpressure();
      test_midpacket_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
